psum_wb_sched: RTL and testbench
================================

# psum_wb_sched

Write-back scheduler for the nine PSUM accumulators of a PEB. It shares the single global-buffer write port among the PSUM units. It grants one requesting PSUM at a time in round-robin order, streams a fixed-length burst of rows to the port with a valid/ready handshake, and generates per-PSUM write addresses. It sits between the PSUM units and the GB write interface and reports block-level write-back completion to the PEB controller.

## Interface
Parameters:
- NUM_PSUM, 9, number of PSUM requesters
- DATA_WIDTH, 64, PSUM beat width
- BURST_LEN, `LENROW, beats per grant
- ADDR_STRIDE, 256, address slots per PSUM per block; power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- blk_sta  in  1  pulse; start of block, synchronous clear/abort
- blk_end  in  1  pulse; arbitration for the block finished upstream
- psum_req  in  NUM_PSUM  level; PSUM i holds ≥BURST_LEN beats ready
- psum_dat  in  NUM_PSUM*DATA_WIDTH  flat beat data, PSUM i at [i*DATA_WIDTH +: DATA_WIDTH]
- psum_rd  out  NUM_PSUM  one-hot pop strobe to granted PSUM
- psum_gnt  out  NUM_PSUM  one-hot grant, held for the whole burst
- gb_val  out  1  write valid
- gb_dat  out  DATA_WIDTH  write data
- gb_addr  out  C_LOG_2(NUM_PSUM)+C_LOG_2(ADDR_STRIDE)  write address = {gnt_id, wr_cnt[gnt_id]}
- gb_rdy  in  1  GB accepts beat
- busy  out  1  state != IDLE
- wb_done  out  1  one-cycle pulse; block write-back complete

## Operation
- States: IDLE, XFER.
- IDLE → XFER when |psum_req. Winner is the first set request strictly after rr_ptr, wrapping modulo NUM_PSUM. The winner is registered into gnt_id and psum_gnt.
- XFER:
  - gb_val=1; gb_dat = psum_dat[gnt_id]; gb_addr per formula above.
  - Handshake hs = gb_val & gb_rdy.
  - On hs: psum_rd[gnt_id]=1 (combinational, same cycle), beat_cnt+1, wr_cnt[gnt_id]+1.
  - wr_cnt is C_LOG_2(ADDR_STRIDE) bits and wraps silently.
- Last beat (beat_cnt==BURST_LEN-1 & hs): rr_ptr ← gnt_id, beat_cnt ← 0, psum_gnt ← 0, → IDLE.
- psum_req is sampled only in IDLE. Deassertion during XFER is ignored; the requester guarantees data for all beats.
- blk_end sets end_pend. wb_done=1 for one cycle when end_pend & state==IDLE & ~|psum_req, which also clears end_pend.
- blk_sta, in any state: next cycle state=IDLE, gb_val=0, psum_gnt=0, beat_cnt=0, all wr_cnt=0, end_pend=0, rr_ptr=NUM_PSUM-1. blk_sta has priority over hs and blk_end in the same cycle.
- Reset values: gb_val 0, psum_gnt 0, psum_rd 0, gb_dat 0, gb_addr 0, busy 0, wb_done 0, rr_ptr NUM_PSUM-1 (so PSUM 0 wins first), all counters 0.

## Timing
- psum_req rising in IDLE → psum_gnt and gb_val high the next cycle (1-cycle latency).
- Burst completes in ≥BURST_LEN cycles. With gb_rdy constantly high it takes exactly BURST_LEN cycles.
- There is one dead IDLE cycle between consecutive bursts, so the minimum period is BURST_LEN+1.
- While gb_val=1 & gb_rdy=0, gb_dat and gb_addr are held stable. gb_val never drops mid-burst except on blk_sta.
- psum_rd is never asserted without hs. At most one bit of psum_rd and psum_gnt is set.
- blk_end coinciding with the last beat: wb_done no earlier than the following IDLE cycle.
- wb_done never coincides with gb_val=1.

## Structure
- Add to the shared include (dw_params_presim.vh): `PSUM_NUM (9) and `PSUM_ADDR_STRIDE (256). Use the existing `C_LOG_2 and `LENROW.
- Sub-module psum_rr_pick:
  - Combinational rotate-priority-rotate picker.
  - Inputs: req[NUM], ptr.
  - Outputs: id, onehot, any.
- Top module holds the FSM, beat/wr counters, data mux and end/done logic.

## Test plan
- Single requester: psum_req=9'h008, gb_rdy=1 → gnt=9'h008 for 14 cycles, addr {3,0}..{3,13}, 14 psum_rd[3] pulses, then IDLE.
- All requesting: psum_req=9'h1FF held → grant order 0,1,…,8,0. Each burst is 14 beats with one gap cycle.
- Backpressure: gb_rdy toggled 1010… → burst takes 28 cycles. Data and address stay stable while rdy=0, and psum_rd pulses only on hs.
- Completion: blk_end during PSUM 5's burst while PSUM 6 also requests → wb_done pulses exactly once, one cycle after PSUM 6's burst ends.
- Abort: blk_sta at beat 7 → gb_val=0 next cycle, wr_cnt cleared. The next grant goes to PSUM 0 with addr {0,0}.
- Wrap: 19 bursts from PSUM 2 with stride 256 → the beat after addr {2,255} goes to {2,0}.

Source files
------------

// File: rtl/psum_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_wb_sched_pkg
// Brief    : Shared constants, state encoding and width helper for the PSUM
//            write-back scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package psum_wb_sched_pkg;

    localparam int LENROW           = 14;
    localparam int PSUM_NUM         = 9;
    localparam int PSUM_ADDR_STRIDE = 256;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } wb_state_e;

    // Never returns zero so single-entry fields still get one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : psum_rr_pick
// Brief    : Combinational round-robin picker; first request strictly after
//            ptr_i, wrapping modulo NUM.
// Revision : 1.0 - initial release
// ============================================================================
module psum_rr_pick
    import psum_wb_sched_pkg::*;
#(
    parameter int NUM  = 9,
    parameter int ID_W = clog2_min1(9)
) (
    input  logic [NUM-1:0]  req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] id_o,
    output logic [NUM-1:0]  onehot_o,
    output logic            any_o
);

    logic [2*NUM-1:0] w_dbl;
    logic [NUM-1:0]   w_rot;
    logic [ID_W:0]    w_start;
    logic [ID_W:0]    w_k;
    logic [ID_W:0]    w_sum;
    logic [ID_W:0]    w_id_ext;

    assign w_dbl   = {req_i, req_i};
    assign w_start = (ID_W+1)'(ptr_i) + (ID_W+1)'(1);
    // Bit k of the rotated view is requester (ptr+1+k) mod NUM.
    assign w_rot   = w_dbl[w_start +: NUM];

    always_comb begin
        w_k = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_k = (ID_W+1)'(k);
            end
        end
    end

    assign w_sum    = w_start + w_k;
    assign w_id_ext = (w_sum >= (ID_W+1)'(NUM)) ? (w_sum - (ID_W+1)'(NUM)) : w_sum;
    assign id_o     = w_id_ext[ID_W-1:0];
    assign any_o    = |req_i;
    assign onehot_o = any_o ? ({{(NUM-1){1'b0}}, 1'b1} << id_o) : '0;

endmodule
`default_nettype wire

// File: rtl/psum_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : psum_wb_sched
// Brief    : Round-robin write-back scheduler sharing one GB write port among
//            the PSUM accumulators, with per-PSUM address counters.
// Revision : 1.0 - initial release
// ============================================================================
module psum_wb_sched
    import psum_wb_sched_pkg::*;
#(
    parameter int NUM_PSUM    = PSUM_NUM,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_LEN   = LENROW,
    parameter int ADDR_STRIDE = PSUM_ADDR_STRIDE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                blk_sta_i,
    input  logic                                blk_end_i,
    input  logic [NUM_PSUM-1:0]                 psum_req_i,
    input  logic [NUM_PSUM*DATA_WIDTH-1:0]      psum_dat_i,
    output logic [NUM_PSUM-1:0]                 psum_rd_o,
    output logic [NUM_PSUM-1:0]                 psum_gnt_o,
    output logic                                gb_val_o,
    output logic [DATA_WIDTH-1:0]               gb_dat_o,
    output logic [clog2_min1(NUM_PSUM)+clog2_min1(ADDR_STRIDE)-1:0] gb_addr_o,
    input  logic                                gb_rdy_i,
    output logic                                busy_o,
    output logic                                wb_done_o
);

    localparam int IDW = clog2_min1(NUM_PSUM);
    localparam int CW  = clog2_min1(ADDR_STRIDE);
    localparam int BW  = clog2_min1(BURST_LEN);

    wb_state_e             state_q, state_d;
    logic [IDW-1:0]        gnt_id_q, gnt_id_d;
    logic [NUM_PSUM-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  end_pend_q, end_pend_d;
    logic [CW-1:0]         wr_cnt_q [NUM_PSUM];
    logic [CW-1:0]         wr_cnt_d [NUM_PSUM];

    logic [DATA_WIDTH-1:0] w_dat [NUM_PSUM];
    logic [IDW-1:0]        w_pick_id;
    logic [NUM_PSUM-1:0]   w_pick_oh;
    logic                  w_pick_any;
    logic                  w_xfer;
    logic                  w_hs;
    logic                  w_last;

    for (genvar g = 0; g < NUM_PSUM; g++) begin : g_unpack
        assign w_dat[g] = psum_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    psum_rr_pick #(
        .NUM  (NUM_PSUM),
        .ID_W (IDW)
    ) u_pick (
        .req_i    (psum_req_i),
        .ptr_i    (rr_ptr_q),
        .id_o     (w_pick_id),
        .onehot_o (w_pick_oh),
        .any_o    (w_pick_any)
    );

    assign w_xfer     = (state_q == ST_XFER);
    assign w_hs       = w_xfer & gb_rdy_i;
    assign w_last     = w_hs & (beat_cnt_q == BW'(BURST_LEN - 1));

    assign gb_val_o   = w_xfer;
    assign gb_dat_o   = w_xfer ? w_dat[gnt_id_q] : '0;
    assign gb_addr_o  = w_xfer ? {gnt_id_q, wr_cnt_q[gnt_id_q]} : '0;
    assign psum_rd_o  = w_hs ? gnt_q : '0;
    assign psum_gnt_o = gnt_q;
    assign busy_o     = w_xfer;
    assign wb_done_o  = end_pend_q & ~w_xfer & ~(|psum_req_i);

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        end_pend_d = end_pend_q;
        wr_cnt_d   = wr_cnt_q;

        if (blk_sta_i) begin
            // Block start aborts everything, including an in-flight beat.
            state_d    = ST_IDLE;
            gnt_id_d   = '0;
            gnt_d      = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = IDW'(NUM_PSUM - 1);
            end_pend_d = 1'b0;
            for (int i = 0; i < NUM_PSUM; i++) begin
                wr_cnt_d[i] = '0;
            end
        end else begin
            if (blk_end_i) begin
                end_pend_d = 1'b1;
            end else if (wb_done_o) begin
                end_pend_d = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        state_d  = ST_XFER;
                        gnt_id_d = w_pick_id;
                        gnt_d    = w_pick_oh;
                    end
                end
                ST_XFER: begin
                    if (w_hs) begin
                        beat_cnt_d         = beat_cnt_q + BW'(1);
                        wr_cnt_d[gnt_id_q] = wr_cnt_q[gnt_id_q] + CW'(1);
                    end
                    if (w_last) begin
                        beat_cnt_d = '0;
                        gnt_d      = '0;
                        rr_ptr_d   = gnt_id_q;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= IDW'(NUM_PSUM - 1);
            end_pend_q <= 1'b0;
            for (int i = 0; i < NUM_PSUM; i++) begin
                wr_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            end_pend_q <= end_pend_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_wb_sched
// Brief    : Self-checking bench for psum_wb_sched with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_wb_sched;

    localparam int N   = 9;
    localparam int DW  = 64;
    localparam int BL  = 14;
    localparam int STR = 256;
    localparam int AW  = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sta = 1'b0;
    logic            endi = 1'b0;
    logic            rdy = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] dat = '0;
    logic [N-1:0]    rd, gnt;
    logic            val, busy, done;
    logic [DW-1:0]   gdat;
    logic [AW-1:0]   addr;

    always #5 clk = ~clk;

    psum_wb_sched #(
        .NUM_PSUM    (N),
        .DATA_WIDTH  (DW),
        .BURST_LEN   (BL),
        .ADDR_STRIDE (STR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_sta_i  (sta),
        .blk_end_i  (endi),
        .psum_req_i (req),
        .psum_dat_i (dat),
        .psum_rd_o  (rd),
        .psum_gnt_o (gnt),
        .gb_val_o   (val),
        .gb_dat_o   (gdat),
        .gb_addr_o  (addr),
        .gb_rdy_i   (rdy),
        .busy_o     (busy),
        .wb_done_o  (done)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: which PSUM owns the port, how many beats it has sent,
    // and each PSUM's next write slot.
    bit m_busy = 0;
    int m_gid = 0;
    int m_beat = 0;
    int m_ptr = N - 1;
    bit m_endp = 0;
    int m_wr [N];

    logic [N-1:0]  o_rd, o_gnt;
    logic          o_val, o_busy, o_done;
    logic [AW-1:0] o_addr;

    typedef struct {
        logic [N-1:0] req;
        int           exp_id;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic int oh2id(input logic [N-1:0] v);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step();
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_dat;
        logic [AW-1:0] e_addr;
        bit            e_done;
        bit            found;
        int            idx;
        for (int w = 0; w < N*DW/32; w++) dat[w*32 +: 32] = $urandom;
        #1;
        e_gnt  = m_busy ? (N'(1) << m_gid) : '0;
        e_dat  = m_busy ? dat[m_gid*DW +: DW] : '0;
        e_addr = m_busy ? AW'(m_gid * STR + m_wr[m_gid]) : '0;
        e_done = m_endp && !m_busy && (req == 0);
        chk("gb_val",   {63'd0, val},  {63'd0, m_busy});
        chk("busy",     {63'd0, busy}, {63'd0, m_busy});
        chk("psum_gnt", DW'(gnt),      DW'(e_gnt));
        chk("psum_rd",  DW'(rd),       (m_busy && rdy) ? DW'(e_gnt) : '0);
        chk("gb_dat",   gdat,          e_dat);
        chk("gb_addr",  DW'(addr),     DW'(e_addr));
        chk("wb_done",  {63'd0, done}, {63'd0, e_done});
        o_rd = rd; o_gnt = gnt; o_val = val; o_busy = busy; o_done = done; o_addr = addr;

        if (rst_n) begin
            if (sta) begin
                m_busy = 0; m_beat = 0; m_endp = 0; m_ptr = N - 1;
                for (int i = 0; i < N; i++) m_wr[i] = 0;
            end else begin
                if (endi) m_endp = 1;
                else if (e_done) m_endp = 0;
                if (!m_busy) begin
                    found = 0;
                    for (int off = 1; off <= N; off++) begin
                        idx = (m_ptr + off) % N;
                        if (!found && req[idx]) begin
                            found = 1; m_gid = idx; m_busy = 1;
                        end
                    end
                end else if (rdy) begin
                    m_wr[m_gid] = (m_wr[m_gid] + 1) % STR;
                    m_beat++;
                    if (m_beat == BL) begin
                        m_beat = 0; m_busy = 0; m_ptr = m_gid;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic block_start();
        sta = 1'b1;
        step();
        sta = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nrd, nv, ng, nhs, ndone, done_i, last6, prevg_id;
        bit fin, seen6;
        logic [N-1:0] prevg;
        logic [N-1:0] one;
        int ids [10];
        int starts [10];

        for (int i = 0; i < N; i++) m_wr[i] = 0;
        one = N'(1);
        tbl[0] = '{9'h008, 3};
        tbl[1] = '{9'h1FF, 0};
        tbl[2] = '{9'h100, 8};
        tbl[3] = '{9'h0A0, 5};
        tbl[4] = '{9'h006, 1};
        tbl[5] = '{9'h180, 7};

        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // First grant after a block start goes to the lowest requester.
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            block_start();
            req = tbl[k].req;
            step();
            req = '0;
            step();
            chk("tbl_gnt",  DW'(o_gnt),  DW'(one << tbl[k].exp_id));
            chk("tbl_addr", DW'(o_addr), DW'(tbl[k].exp_id * STR));
        end

        // Single requester, full-rate burst.
        block_start();
        rdy = 1'b1; req = 9'h008;
        step();
        req = '0; nrd = 0;
        for (int k = 0; k < BL; k++) begin
            step();
            chk("single_gnt",  DW'(o_gnt),  DW'(9'h008));
            chk("single_addr", DW'(o_addr), DW'(12'h300 + k));
            if (o_rd[3]) nrd++;
        end
        step();
        chk("single_idle", DW'(o_busy), 0);
        chk("single_rd_cnt", DW'(nrd), BL);

        // Everyone requesting: strict rotation with one idle gap per burst.
        block_start();
        req = 9'h1FF; rdy = 1'b1; prevg = '0; ng = 0;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            step();
            if (o_gnt != 0 && prevg == 0) begin
                ids[ng] = oh2id(o_gnt); starts[ng] = i; ng++;
            end
            prevg = o_gnt;
        end
        req = '0;
        chk("allreq_count", DW'(ng), 10);
        for (int k = 0; k < ng; k++) begin
            chk("allreq_order", DW'(ids[k]), DW'(k % N));
            if (k > 0) chk("allreq_period", DW'(starts[k] - starts[k-1]), BL + 1);
        end
        step();

        // Backpressure: ready low on every other beat slot.
        block_start();
        req = 9'h008; rdy = 1'b0;
        step();
        req = '0; nv = 0; nrd = 0; fin = 0;
        for (int i = 0; i < 100 && !fin; i++) begin
            rdy = (i % 2) == 1;
            step();
            if (o_val) nv++; else fin = 1;
            if (o_rd != 0) nrd++;
        end
        chk("bp_cycles", DW'(nv), 2 * BL);
        chk("bp_rd_cnt", DW'(nrd), BL);

        // Completion: blk_end during PSUM 5's burst, PSUM 6 waiting.
        block_start();
        rdy = 1'b1; req = 9'h060;
        step();
        seen6 = 0; ndone = 0; done_i = -1; last6 = -1;
        for (int i = 0; i < 40; i++) begin
            req  = seen6 ? '0 : 9'h040;
            endi = (i == 3);
            step();
            if (o_gnt == 9'h040) begin seen6 = 1; last6 = i; end
            if (o_done) begin ndone++; done_i = i; end
        end
        endi = 1'b0;
        chk("done_count", DW'(ndone), 1);
        chk("done_time",  DW'(done_i), DW'(last6 + 1));

        // Abort mid-burst at beat 7.
        block_start();
        rdy = 1'b1; req = 9'h008;
        step();
        req = '0;
        for (int k = 0; k < 7; k++) step();
        block_start();
        step();
        chk("abort_val", DW'(o_val), 0);
        chk("abort_gnt", DW'(o_gnt), 0);
        req = 9'h1FF;
        step();
        req = '0;
        step();
        chk("abort_regnt", DW'(o_gnt),  DW'(9'h001));
        chk("abort_addr",  DW'(o_addr), 0);
        for (int k = 0; k < BL; k++) step();

        // Address wrap for PSUM 2 over 19 bursts.
        block_start();
        rdy = 1'b1; nhs = 0;
        for (int b = 0; b < 19; b++) begin
            req = 9'h004;
            step();
            req = '0;
            for (int k = 0; k < BL; k++) begin
                step();
                if (o_rd[2]) begin
                    if (nhs == 255) chk("wrap_top",  DW'(o_addr), DW'(12'h2FF));
                    if (nhs == 256) chk("wrap_zero", DW'(o_addr), DW'(12'h200));
                    nhs++;
                end
            end
        end
        chk("wrap_beats", DW'(nhs), 19 * BL);

        // Randomized traffic against the model.
        block_start();
        for (int i = 0; i < 3000; i++) begin
            req  = ($urandom % 4 == 0) ? N'($urandom) : '0;
            rdy  = ($urandom % 4) != 0;
            endi = ($urandom % 50) == 0;
            sta  = ($urandom % 400) == 0;
            step();
        end
        sta = 1'b0; endi = 1'b0; req = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
